// File: rtl/pci_parity_err_reporter.sv
// PCI parity error reporter: checks address and received-data phases one clock late,
// drives PERR#/SERR# with 2-clock timing and holds the sticky DPE bit.
// Optional saturating error counter: define PCI_PERR_CNT_EN.
module pci_parity_err_reporter #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [31:0]      AD,
  input  logic [3:0]       CBE_N,
  input  logic             PAR,
  input  logic             FRAME_N,
  input  logic             IRDY_N,
  input  logic             TRDY_N,
  input  logic             RX_DATA,
  input  logic             PERR_RESP_EN,
  input  logic             SERR_EN,
  input  logic             STAT_CLR,
  output logic             PERR_N_O,
  output logic             PERR_OE,
  output logic             SERR_N_O,
  output logic             SERR_OE,
  output logic             DPE,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]  state, state_nxt;
  logic        addr_phase, data_phase;
  logic [31:0] ad_q;
  logic [3:0]  cbe_q;
  logic        addr_flag_q, data_flag_q;
  logic        parity_err, addr_err, data_err;
  logic        perr_fire, serr_fire, any_err;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!FRAME_N) state_nxt = ST_ADDR;
      ST_ADDR: state_nxt = ST_DATA;
      ST_DATA: if (FRAME_N && IRDY_N) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign addr_phase = (state == ST_IDLE) && !FRAME_N;
  assign data_phase = (state == ST_DATA) && !IRDY_N && !TRDY_N && RX_DATA;

  // NOTE: clocked state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      addr_flag_q <= 1'b0;
      data_flag_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr_flag_q <= addr_phase;
      data_flag_q <= data_phase;
    end
  end

  // NOTE: the captured bus needs no reset; it is only used when a phase flag is set.
  always_ff @(posedge CLK) begin
    ad_q  <= AD;
    cbe_q <= CBE_N;
  end

  // PAR arrives one clock after the bits it covers; even parity over all 37 bits.
  assign parity_err = (^ad_q) ^ (^cbe_q) ^ PAR;
  assign addr_err   = addr_flag_q & parity_err;
  assign data_err   = data_flag_q & parity_err;
  assign any_err    = addr_err | data_err;
  assign perr_fire  = data_err & PERR_RESP_EN;
  assign serr_fire  = addr_err & SERR_EN & PERR_RESP_EN;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      PERR_N_O <= 1'b1;
      PERR_OE  <= 1'b0;
      SERR_N_O <= 1'b1;
      SERR_OE  <= 1'b0;
      DPE      <= 1'b0;
    end else begin
      PERR_N_O <= ~perr_fire;
      // Keep driving one extra clock after the last low so PERR# is actively restored high.
      PERR_OE  <= perr_fire | ~PERR_N_O;
      SERR_N_O <= ~serr_fire;
      SERR_OE  <= serr_fire;
      DPE      <= any_err | (DPE & ~STAT_CLR);
    end
  end

`ifdef PCI_PERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      err_cnt <= '0;
    end else if (any_err) begin
      if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
    end else if (STAT_CLR) begin
      err_cnt <= '0;
    end
  end

  assign ERR_CNT = err_cnt;
`else
  assign ERR_CNT = '0;
`endif

endmodule
